// File: rtl/press_pkg.sv
// Shared types and default thresholds for the press classifier.
// States GAP and SECOND are only used when PRESS_DOUBLE_EN is defined.
package press_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        GAP,
        SECOND
    } press_state_e;

    localparam int LONG_TICKS_DEF   = 500;
    localparam int DOUBLE_TICKS_DEF = 250;
    localparam int CNT_W_DEF        = 10;

endpackage

// File: rtl/press_tick_counter.sv
// Tick counter: clears on state entry, counts timebase ticks, flags the tick reaching limit.
// Latency: hit is combinational from the current count and tick; count updates on the next edge.
// Backpressure: none; the counter saturates instead of wrapping.
module press_tick_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + 1'b1;
    assign hit     = tick & (cnt_inc == limit);

    // Saturation keeps long holds from wrapping back onto a threshold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick && (cnt != '1)) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/press_classifier.sv
// Classifies a debounced button level into short/long/double press pulses; double detection under PRESS_DOUBLE_EN.
// Latency: event pulses are registered, high for the one cycle after the edge that sampled the condition.
// Backpressure: none; events are fire-and-forget pulses, hold and busy are levels.
module press_classifier
    import press_pkg::*;
#(
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int DOUBLE_TICKS = DOUBLE_TICKS_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    input  logic tick,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic hold,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] DOUBLE_LIM = CNT_W'(DOUBLE_TICKS);

    press_state_e     state;
    press_state_e     state_nx;
    logic             btn_q;
    logic             rise;
    logic             fall;
    logic             hit;
    logic             clear;
    logic [CNT_W-1:0] limit;
    logic             short_nx;
    logic             long_nx;
`ifdef PRESS_DOUBLE_EN
    logic             double_nx;
`endif

    assign rise  = btn_level & ~btn_q;
    assign fall  = ~btn_level & btn_q;
    assign clear = (state_nx != state);
    assign limit = (state == PRESSED) ? LONG_LIM : DOUBLE_LIM;
    assign hold  = (state == LONG_HELD);
    assign busy  = (state != IDLE);

    press_tick_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick),
        .limit (limit),
        .hit   (hit)
    );

    always_comb begin
        state_nx = state;
        short_nx = 1'b0;
        long_nx  = 1'b0;
`ifdef PRESS_DOUBLE_EN
        double_nx = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rise) state_nx = PRESSED;
            end
            PRESSED: begin
                // A release on the threshold tick still counts as a short press.
                if (fall) begin
`ifdef PRESS_DOUBLE_EN
                    state_nx = GAP;
`else
                    state_nx = IDLE;
                    short_nx = 1'b1;
`endif
                end else if (hit) begin
                    state_nx = LONG_HELD;
                    long_nx  = 1'b1;
                end
            end
            LONG_HELD: begin
                if (fall) state_nx = IDLE;
            end
`ifdef PRESS_DOUBLE_EN
            GAP: begin
                if (rise) begin
                    state_nx = SECOND;
                end else if (hit) begin
                    state_nx = IDLE;
                    short_nx = 1'b1;
                end
            end
            SECOND: begin
                if (fall) begin
                    state_nx  = IDLE;
                    double_nx = 1'b1;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            btn_q       <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            state       <= state_nx;
            btn_q       <= btn_level;
            short_press <= short_nx;
            long_press  <= long_nx;
        end
    end

`ifdef PRESS_DOUBLE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            double_press <= 1'b0;
        end else begin
            double_press <= double_nx;
        end
    end
`else
    assign double_press = 1'b0;
`endif

endmodule
